// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over req/ready, holds until ack.
// Optional MIPS_FETCH_PERF_EN adds fetch and wait-cycle counters.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jump_address,
    input  logic [31:0] jr_target,
`ifdef MIPS_FETCH_PERF_EN
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_wait_cycles,
`endif
    output logic        fault
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]  state;
    logic [31:0] next_pc;

    assign mem_req  = (state == S_FETCH);
    assign mem_addr = pc;
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        unique case (pc_sel)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + branch_offset;
            2'b10: next_pc = jump_address;
            2'b11: next_pc = jr_target;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        instr       <= mem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ack) begin
                        instr_valid <= 1'b0;
                        // A misaligned target is trapped before it ever reaches memory
                        if (next_pc[1:0] == 2'b00) begin
                            pc    <= next_pc;
                            state <= S_FETCH;
                        end else begin
                            fault <= 1'b1;
                            state <= S_FAULT;
                        end
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                    state       <= S_FAULT;
                end
            endcase
        end
    end

`ifdef MIPS_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetches     <= 32'h0;
            perf_wait_cycles <= 32'h0;
        end else if (state == S_FETCH) begin
            if (mem_ready) begin
                perf_fetches <= perf_fetches + 32'd1;
            end else begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
